// File: rtl/dataflow_carry.sv
// dataflow_carry: loop-carried value merge of init and loop-back streams.
// Define DATAFLOW_CARRY_OUT_REG_EN for a one-entry registered output stage.
module dataflow_carry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cond_valid,
  output logic             cond_ready,
  input  logic             cond_data,
  input  logic             init_valid,
  output logic             init_ready,
  input  logic [WIDTH-1:0] init_data,
  input  logic             next_valid,
  output logic             next_ready,
  input  logic [WIDTH-1:0] next_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             in_loop,
  output logic [15:0]      iter_count
);

  typedef enum logic {
    S_INIT,
    S_LOOP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_iter;
  logic [15:0]      w_iter_nxt;
  logic             w_can_emit;
  logic [WIDTH-1:0] w_sel_data;

  assign w_sel_data = (r_state == S_INIT) ? init_data : next_data;

`ifdef DATAFLOW_CARRY_OUT_REG_EN
  logic             r_slot_valid;
  logic [WIDTH-1:0] r_slot_data;
  logic             w_emit;

  assign w_can_emit = !r_slot_valid || out_ready;
  // next_ready is only high on a continue fire with next_valid set
  assign w_emit     = (init_valid && init_ready) || next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_valid <= 1'b0;
      r_slot_data  <= '0;
    end else if (w_emit) begin
      r_slot_valid <= 1'b1;
      r_slot_data  <= w_sel_data;
    end else if (out_ready) begin
      r_slot_valid <= 1'b0;
    end
  end

  assign out_valid = r_slot_valid && !rst;
  assign out_data  = r_slot_data;
`else
  assign w_can_emit = out_ready;
  assign out_valid  = !rst &&
    (((r_state == S_INIT) && init_valid) ||
     ((r_state == S_LOOP) && cond_valid &&
      cond_data && next_valid));
  assign out_data   = w_sel_data;
`endif

  always_comb begin
    init_ready  = 1'b0;
    cond_ready  = 1'b0;
    next_ready  = 1'b0;
    w_state_nxt = r_state;
    w_iter_nxt  = r_iter;
    if (!rst) begin
      unique case (r_state)
        S_INIT: begin
          init_ready = w_can_emit;
          if (init_valid && w_can_emit) begin
            w_iter_nxt  = '0;
            w_state_nxt = S_LOOP;
          end
        end
        S_LOOP: begin
          unique case (1'b1)
            (cond_valid && cond_data): begin
              cond_ready = next_valid && w_can_emit;
              next_ready = next_valid && w_can_emit;
              if (next_valid && w_can_emit) begin
                if (r_iter != 16'hFFFF)
                  w_iter_nxt = r_iter + 16'd1;
              end
            end
            (cond_valid && !cond_data): begin
              cond_ready  = 1'b1;
              w_state_nxt = S_INIT;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  assign in_loop    = (r_state == S_LOOP);
  assign iter_count = r_iter;

endmodule

// File: tb/tb_dataflow_carry.sv
// Directed self-checking bench for dataflow_carry.
// Output ordering is checked through a handshake monitor queue.
module tb_dataflow_carry;

  logic        clk = 1'b0;
  logic        rst;
  logic        cond_valid, cond_ready, cond_data;
  logic        init_valid, init_ready;
  logic [31:0] init_data;
  logic        next_valid, next_ready;
  logic [31:0] next_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        in_loop;
  logic [15:0] iter_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  dataflow_carry #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cond_valid (cond_valid),
    .cond_ready (cond_ready),
    .cond_data  (cond_data),
    .init_valid (init_valid),
    .init_ready (init_ready),
    .init_data  (init_data),
    .next_valid (next_valid),
    .next_ready (next_ready),
    .next_data  (next_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .in_loop    (in_loop),
    .iter_count (iter_count)
  );

  always @(posedge clk)
    if (!rst && out_valid && out_ready)
      q.push_back(out_data);

  task automatic send_init(input logic [31:0] v);
    bit ok;
    ok = 0;
    init_valid = 1'b1;
    init_data  = v;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (init_ready) begin
        ok = 1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    init_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL init_handshake value %0d: no init_ready in 50 cycles", v);
    else n_pass++;
  endtask

  task automatic send_cond(input logic c, input logic [31:0] n);
    bit ok;
    ok = 0;
    cond_valid = 1'b1;
    cond_data  = c;
    next_valid = c;
    next_data  = n;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (cond_ready) begin
        ok = 1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cond_valid = 1'b0;
    next_valid = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL cond_handshake cond=%0b: no cond_ready in 50 cycles", c);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cond_valid = 0; cond_data = 0;
    init_valid = 0; init_data = 0;
    next_valid = 0; next_data = 0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_valid = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (init_ready !== 1'b0) $display("FAIL rst_init_ready got %0b want 0", init_ready);
    else n_pass++;
    n_checks++;
    if (in_loop !== 1'b0) $display("FAIL rst_in_loop got %0b want 0", in_loop);
    else n_pass++;
    n_checks++;
    if (iter_count !== 16'd0) $display("FAIL rst_iter got %0d want 0", iter_count);
    else n_pass++;
    init_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (init_ready !== 1'b1) $display("FAIL post_rst_init_ready got %0b want 1", init_ready);
    else n_pass++;
    n_checks++;
    if (cond_ready !== 1'b0 || next_ready !== 1'b0)
      $display("FAIL post_rst_loop_ready got %0b%0b want 00", cond_ready, next_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_basic_loop();
    q.delete();
    send_init(32'd5);
    n_checks++;
    if (in_loop !== 1'b1) $display("FAIL basic_in_loop got %0b want 1", in_loop);
    else n_pass++;
    n_checks++;
    if (iter_count !== 16'd0) $display("FAIL basic_iter0 got %0d want 0", iter_count);
    else n_pass++;
    send_cond(1'b1, 32'd7);
    send_cond(1'b1, 32'd9);
    send_cond(1'b0, 32'd0);
    n_checks++;
    if (in_loop !== 1'b0) $display("FAIL basic_exit_in_loop got %0b want 0", in_loop);
    else n_pass++;
    n_checks++;
    if (iter_count !== 16'd2) $display("FAIL basic_iter got %0d want 2", iter_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() !== 3) $display("FAIL basic_count got %0d want 3", q.size());
    else n_pass++;
    if (q.size() == 3) begin
      n_checks++;
      if (q[0] !== 32'd5 || q[1] !== 32'd7 || q[2] !== 32'd9)
        $display("FAIL basic_seq got %0d,%0d,%0d want 5,7,9", q[0], q[1], q[2]);
      else n_pass++;
    end
  endtask

  task automatic test_exit_immediate();
    q.delete();
    next_valid = 1'b1;
    next_data  = 32'hAA;
    #1;
    n_checks++;
    if (next_ready !== 1'b0) $display("FAIL exit_next_ready_init got %0b want 0", next_ready);
    else n_pass++;
    send_init(32'd3);
    next_valid = 1'b1;
    cond_valid = 1'b1;
    cond_data  = 1'b0;
    #1;
    n_checks++;
    if (cond_ready !== 1'b1) $display("FAIL exit_cond_ready got %0b want 1", cond_ready);
    else n_pass++;
    n_checks++;
    if (next_ready !== 1'b0) $display("FAIL exit_next_ready got %0b want 0", next_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    cond_valid = 1'b0;
    #1;
    n_checks++;
    if (in_loop !== 1'b0) $display("FAIL exit_in_loop got %0b want 0", in_loop);
    else n_pass++;
    n_checks++;
    if (next_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL exit_idle got nr=%0b ov=%0b want 0,0", next_ready, out_valid);
    else n_pass++;
    next_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() !== 1 || q[0] !== 32'd3)
      $display("FAIL exit_seq got size %0d want single 3", q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    q.delete();
`ifdef DATAFLOW_CARRY_OUT_REG_EN
    out_ready = 1'b0;
    send_init(32'd4);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd4)
      $display("FAIL bp_hold got %0b/%0d want 1/4", out_valid, out_data);
    else n_pass++;
    cond_valid = 1'b1; cond_data = 1'b1;
    next_valid = 1'b1; next_data = 32'd8;
    #1;
    n_checks++;
    if (next_ready !== 1'b0 || cond_ready !== 1'b0)
      $display("FAIL bp_stall got %0b%0b want 00", cond_ready, next_ready);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd4 || next_ready !== 1'b0)
      $display("FAIL bp_hold2 got %0b/%0d nr=%0b", out_valid, out_data, next_ready);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (next_ready !== 1'b1) $display("FAIL bp_release got %0b want 1", next_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    cond_valid = 1'b0;
    next_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd8)
      $display("FAIL bp_nogap got %0b/%0d want 1/8", out_valid, out_data);
    else n_pass++;
`else
    out_ready  = 1'b0;
    init_valid = 1'b1;
    init_data  = 32'd4;
    #1;
    n_checks++;
    if (init_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd4)
      $display("FAIL bp_init got ir=%0b ov=%0b od=%0d", init_ready, out_valid, out_data);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (init_ready !== 1'b1) $display("FAIL bp_init_release got %0b want 1", init_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    init_valid = 1'b0;
    out_ready  = 1'b0;
    cond_valid = 1'b1; cond_data = 1'b1;
    next_valid = 1'b1; next_data = 32'd8;
    #1;
    n_checks++;
    if (next_ready !== 1'b0 || cond_ready !== 1'b0 || out_data !== 32'd8)
      $display("FAIL bp_stall got %0b%0b od=%0d", cond_ready, next_ready, out_data);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (next_ready !== 1'b1) $display("FAIL bp_release got %0b want 1", next_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    cond_valid = 1'b0;
    next_valid = 1'b0;
`endif
    send_cond(1'b0, 32'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() !== 2 || q[0] !== 32'd4 || q[1] !== 32'd8)
      $display("FAIL bp_seq got size %0d want 4,8", q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    q.delete();
    send_init(32'd1);
    send_cond(1'b0, 32'd0);
    n_checks++;
    if (iter_count !== 16'd0) $display("FAIL b2b_iter_a got %0d want 0", iter_count);
    else n_pass++;
    send_init(32'd2);
    send_cond(1'b1, 32'd6);
    send_cond(1'b0, 32'd0);
    n_checks++;
    if (iter_count !== 16'd1) $display("FAIL b2b_iter_b got %0d want 1", iter_count);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() !== 3) $display("FAIL b2b_count got %0d want 3", q.size());
    else n_pass++;
    if (q.size() == 3) begin
      n_checks++;
      if (q[0] !== 32'd1 || q[1] !== 32'd2 || q[2] !== 32'd6)
        $display("FAIL b2b_seq got %0d,%0d,%0d want 1,2,6", q[0], q[1], q[2]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic exp_ir;
`ifdef DATAFLOW_CARRY_OUT_REG_EN
    exp_ir = 1'b1;
`else
    exp_ir = 1'b0;
`endif
    send_init(32'd7);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || init_ready !== 1'b0)
      $display("FAIL midrst_during got ov=%0b ir=%0b want 0,0", out_valid, init_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %0b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_loop !== 1'b0) $display("FAIL midrst_in_loop got %0b want 0", in_loop);
    else n_pass++;
    n_checks++;
    if (init_ready !== exp_ir) $display("FAIL midrst_init_ready got %0b want %0b", init_ready, exp_ir);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (init_ready !== 1'b1) $display("FAIL midrst_ready_on got %0b want 1", init_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    send_init(32'd0);
    cond_valid = 1'b1; cond_data = 1'b1;
    next_valid = 1'b1; next_data = 32'h55;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (iter_count !== 16'hFFFE) $display("FAIL sat_fffe got %0h want fffe", iter_count);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (iter_count !== 16'hFFFF) $display("FAIL sat_ffff got %0h want ffff", iter_count);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (iter_count !== 16'hFFFF) $display("FAIL sat_hold got %0h want ffff", iter_count);
    else n_pass++;
    cond_valid = 1'b0;
    next_valid = 1'b0;
    send_cond(1'b0, 32'd0);
    repeat (2) @(negedge clk);
    q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_loop();
    test_exit_immediate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dataflow_carry.md
DATAFLOW_CARRY -- requirements
Module: dataflow_carry

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of init, next and out payloads (>=1).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: cond_valid input 1, cond_ready output 1, cond_data input 1; the loop-continue flag stream, i.e. the will-continue output of the upstream stream stage.
REQ-005 SHALL have ports: init_valid input 1, init_ready output 1, init_data input WIDTH; the value carried into a new loop activation.
REQ-006 SHALL have ports: next_valid input 1, next_ready output 1, next_data input WIDTH; the loop-back value from the loop body.
REQ-007 SHALL have ports: out_valid output 1, out_ready input 1, out_data output WIDTH; the carried value for the current iteration.
REQ-008 SHALL have port: in_loop  output  1  high while in S_LOOP.
REQ-009 SHALL have port: iter_count  output  16  loop-back values emitted in the current activation, saturating at 16'hFFFF.

Function
REQ-010 SHALL implement a two-state FSM: S_INIT and S_LOOP.
REQ-011 SHALL define can_emit as follows: with the output register compiled in, can_emit is !slot_valid || out_ready; without it, can_emit is out_ready.
REQ-012 In S_INIT, SHALL drive init_ready = can_emit, with cond_ready and next_ready both 0.
REQ-013 In S_INIT, on an init fire (init_valid && init_ready), SHALL emit init_data, clear iter_count to 0, and go to S_LOOP.
REQ-014 In S_LOOP, SHALL hold init_ready at 0.
REQ-015 In S_LOOP with cond_valid && cond_data==1, SHALL drive cond_ready = next_ready = next_valid && can_emit, so cond and next are consumed in the same cycle.
REQ-016 On that continue fire, SHALL emit next_data, increment iter_count (saturating), and stay in S_LOOP.
REQ-017 In S_LOOP with cond_valid && cond_data==0, SHALL drive cond_ready=1 regardless of can_emit and next_ready=0.
REQ-018 On that exit fire, SHALL emit nothing, go to S_INIT, and hold iter_count unchanged until the next init fire.
REQ-019 In S_LOOP with cond_valid==0, SHALL drive every ready low and change no state.
REQ-020 SHALL leave a pending next_valid in S_INIT or on an exit fire unconsumed, with no state change.
REQ-021 SHALL drive in_loop = (state==S_LOOP).
REQ-022 SHALL not pass payloads through any arithmetic: out_data is exactly init_data or next_data, bit for bit.
REQ-023 SHALL not combinationally depend on out_valid or out_data for any ready output, so no ready-to-ready loop exists beyond can_emit.

Reset
REQ-024 While rst is high at a clock edge, SHALL set state to S_INIT, slot_valid to 0, out_data to 0 and iter_count to 0.
REQ-025 While rst is high, SHALL drive out_valid and all ready outputs to 0.
REQ-026 On reset mid-activation, SHALL drop any buffered output value and resume in S_INIT on the first edge with rst low.

Configuration
REQ-027 SHALL use the macro DATAFLOW_CARRY_OUT_REG_EN to select the output stage.
REQ-028 With DATAFLOW_CARRY_OUT_REG_EN defined, SHALL use a one-entry output register.
REQ-029 In that mode, an emitted value SHALL load the slot, with out_valid = slot_valid and out_data = slot register.
REQ-030 In that mode, latency from input fire to out_valid SHALL be 1 cycle.
REQ-031 In that mode, SHALL allow a simultaneous slot drain and refill in one cycle, sustaining 1 value per cycle.
REQ-032 In that mode, the slot SHALL clear when out_ready is high with no refill.
REQ-033 With DATAFLOW_CARRY_OUT_REG_EN undefined, the output SHALL be combinational with 0 latency.
REQ-034 In that mode, out_valid SHALL be (S_INIT && init_valid) || (S_LOOP && cond_valid && cond_data && next_valid).
REQ-035 In that mode, out_data SHALL select init_data in S_INIT and next_data in S_LOOP.

Verification
REQ-036 SHALL cover: init 5, cond 1,1,0, next 7,9, out_ready=1 -> out 5,7,9; in_loop falls after the cond=0 fire; iter_count=2.
REQ-037 SHALL cover: cond=0 immediately after init 3 -> out 3 only; next_valid held high with next_ready=0 throughout.
REQ-038 SHALL cover: output register in, out_ready=0 after init 4 -> out_valid=1, out_data=4 held; next 8 with cond 1 not consumed until out_ready rises; then out 8 follows with no gap.
REQ-039 SHALL cover: back-to-back activations, init 1 with cond 0, then init 2 with cond 1 (next 6) and cond 0 -> out 1,2,6; iter_count reads 0, then 1.
REQ-040 SHALL cover: rst asserted one cycle with value 7 buffered in the slot in S_LOOP -> out_valid=0 next cycle; state S_INIT; init_ready follows can_emit.
REQ-041 SHALL cover: 65537 continue iterations -> iter_count saturates at 65535 with no wrap to 0.
